// File: rtl/projectile_pool_if.sv
// Fire-request bundle between a fighter's controller and its projectile pool.
// Master drives activate/centre/step; slave answers with fire_ack/pool_full.
interface projectile_pool_if;
   logic       activate;
   logic [9:0] Proj_X_Center;
   logic [9:0] Proj_Y_Center;
   logic [9:0] Proj_X_Step;
   logic       fire_ack;
   logic       pool_full;

   modport master (
      output activate, Proj_X_Center, Proj_Y_Center, Proj_X_Step,
      input  fire_ack, pool_full
   );

   modport slave (
      input  activate, Proj_X_Center, Proj_Y_Center, Proj_X_Step,
      output fire_ack, pool_full
   );
endinterface

// File: rtl/projectile_pool.sv
// projectile_pool: NUM_PROJ-slot projectile manager for one shooter.
// Spawns at the shooter centre on a fire request (frame cooldown limited),
// moves each live slot once per frame by its own latched step, retires slots
// on screen-edge exit or hitbox contact, and flags pixels inside any slot.
// Ports: Clk, Reset (sync, active-high), frame_clk (VGA_VS), fire (slave
//   bundle: activate, Proj_X/Y_Center, Proj_X_Step, fire_ack, pool_full),
//   contact[NUM_PROJ], DrawX/DrawY, Proj_X_Pos/Proj_Y_Pos (slot i at
//   [10i+9:10i]), active[NUM_PROJ], is_proj.
// Option: define PROJECTILE_POOL_AUTOFIRE_EN to re-arm the request on every
//   frame while activate is held (default: one shot per press).
module projectile_pool #(
   parameter int NUM_PROJ        = 4,
   parameter int PROJ_SIZE       = 4,
   parameter int COOLDOWN_FRAMES = 15,
   parameter int SCREEN_X_MAX    = 639
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     frame_clk,
   projectile_pool_if.slave         fire,
   input  logic [NUM_PROJ-1:0]      contact,
   input  logic [9:0]               DrawX,
   input  logic [9:0]               DrawY,
   output logic [NUM_PROJ*10-1:0]   Proj_X_Pos,
   output logic [NUM_PROJ*10-1:0]   Proj_Y_Pos,
   output logic [NUM_PROJ-1:0]      active,
   output logic                     is_proj
);

   localparam int IW = (NUM_PROJ > 1) ? $clog2(NUM_PROJ) : 1;
   localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
   localparam logic [9:0] X_LO = 10'(PROJ_SIZE);
   localparam logic [9:0] X_HI = 10'(SCREEN_X_MAX - PROJ_SIZE);
   localparam logic signed [10:0] PS = 11'(PROJ_SIZE);
   localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES - 1);

   logic [NUM_PROJ-1:0][9:0] x_q, x_d;
   logic [NUM_PROJ-1:0][9:0] y_q, y_d;
   logic [NUM_PROJ-1:0][9:0] step_q, step_d;
   logic [NUM_PROJ-1:0]      active_q, active_d;
   logic [CW-1:0]            cool_q, cool_d;
   logic                     pending_q, pending_d;
   logic                     frame_d_q;
   logic                     act_q;
   logic                     fire_ack_q, fire_ack_d;

   logic                     tick;
   logic                     rise;
   logic                     free_found;
   logic [IW-1:0]            free_idx;
   logic                     spawn;
   logic [NUM_PROJ-1:0][10:0] sum;
   logic [NUM_PROJ-1:0]      off_screen;
   logic [NUM_PROJ-1:0][10:0] dx;
   logic [NUM_PROJ-1:0][10:0] dy;
   logic [NUM_PROJ-1:0]      hit_px;

   assign tick = frame_clk & ~frame_d_q;
   assign rise = fire.activate & ~act_q;

   // Lowest-index free slot, judged on the pre-edge occupancy so a slot
   // retired on this tick only becomes available on the following one.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_PROJ - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

   assign spawn = tick & pending_q & (cool_q == '0) & free_found;

   always_comb begin
      pending_d = pending_q;
      if (tick) pending_d = 1'b0;
`ifdef PROJECTILE_POOL_AUTOFIRE_EN
      if (tick && fire.activate) pending_d = 1'b1;
`else
`endif
      // An edge landing on a tick still arms the next frame.
      if (rise) pending_d = 1'b1;
   end

   always_comb begin
      cool_d = cool_q;
      if (spawn)
         cool_d = CD_LOAD;
      else if (tick && cool_q != '0)
         cool_d = cool_q - 1'b1;
   end

   assign fire_ack_d = spawn;

   // Per-slot update: spawn load, frame move with edge retirement, and
   // contact retirement (which overrides the move).
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      step_d     = step_q;
      active_d   = active_q;
      sum        = '0;
      off_screen = '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
         sum[i] = {1'b0, x_q[i]} + {step_q[i][9], step_q[i]};
         // Bit 10 set means negative (or beyond 1023): off screen either way.
         off_screen[i] = sum[i][10]
                       | (sum[i][9:0] < X_LO)
                       | (sum[i][9:0] > X_HI);
         if (spawn && free_idx == IW'(i)) begin
            x_d[i]      = fire.Proj_X_Center;
            y_d[i]      = fire.Proj_Y_Center;
            step_d[i]   = fire.Proj_X_Step;
            active_d[i] = 1'b1;
         end else if (tick && active_q[i]) begin
            if (off_screen[i])
               active_d[i] = 1'b0;
            else
               x_d[i] = sum[i][9:0];
         end
         if (active_q[i] && contact[i]) begin
            active_d[i] = 1'b0;
            x_d[i]      = x_q[i];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_q        <= '0;
         y_q        <= '0;
         step_q     <= '0;
         active_q   <= '0;
         cool_q     <= '0;
         pending_q  <= 1'b0;
         frame_d_q  <= 1'b0;
         act_q      <= 1'b0;
         fire_ack_q <= 1'b0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         step_q     <= step_d;
         active_q   <= active_d;
         cool_q     <= cool_d;
         pending_q  <= pending_d;
         frame_d_q  <= frame_clk;
         act_q      <= fire.activate;
         fire_ack_q <= fire_ack_d;
      end
   end

   // Pixel test with 11-bit signed differences so nothing wraps near 0.
   always_comb begin
      dx     = '0;
      dy     = '0;
      hit_px = '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
         dx[i] = {1'b0, DrawX} - {1'b0, x_q[i]};
         dy[i] = {1'b0, DrawY} - {1'b0, y_q[i]};
         hit_px[i] = active_q[i]
                   & ($signed(dx[i]) <= PS) & ($signed(dx[i]) >= -PS)
                   & ($signed(dy[i]) <= PS) & ($signed(dy[i]) >= -PS);
      end
   end

   assign is_proj        = |hit_px;
   assign active         = active_q;
   assign Proj_X_Pos     = x_q;
   assign Proj_Y_Pos     = y_q;
   assign fire.fire_ack  = fire_ack_q;
   assign fire.pool_full = &active_q;

endmodule
